// File: rtl/led_scan_capture_pkg.sv
// Shared definitions for the 7-segment display path: active-low {a..g} digit patterns
// (identical to the display encoder's) and the anode classification used by the capture.
package led_scan_capture_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_PATTERN [16] = '{
      SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
      SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
   };

   typedef enum logic [1:0] {
      AN_BLANK,
      AN_SINGLE,
      AN_MULTI
   } an_kind_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder: active-low segment pattern -> hex nibble, flagging any pattern
// that is not one of the sixteen digit glyphs.
module seg7_to_hex
   import led_scan_capture_pkg::*;
(
   input  logic [6:0] seg,
   output logic       invalid,
   output logic [3:0] nibble
);

   // NOTE: every output gets a default before the search so no latch is inferred.
   always_comb begin
      invalid = 1'b1;
      nibble  = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_PATTERN[i]) begin
            invalid = 1'b0;
            nibble  = 4'(i);
         end
      end
   end

endmodule

// File: rtl/led_scan_capture.sv
// Receive-side monitor for the 4-digit multiplexed 7-segment display: synchronizes the
// anode/segment lines, takes each digit once it is stable and emits one word per full scan.
module led_scan_capture
   import led_scan_capture_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] data,
   output logic        data_valid,
   output logic        frame_bad,
   output logic        seg_err,
   output logic        an_err,
   output logic        timeout
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_CAP = CW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] TOUT_HIT = TW'(TIMEOUT_CYCLES - 1);

   logic [10:0]     sync1, sync2, s_prev;
   logic [CW-1:0]   cnt;
   logic            taken;
   logic [3:0]      seen, seen_n;
   logic            bad, bad_n;
   logic [3:0][3:0] slots, slots_n;
   logic [TW-1:0]   tcnt;

   an_kind_t        kind;
   logic [1:0]      idx;
   logic            capture, cap_single, cap_invalid, complete, tout_fire;
   logic [3:0]      cap_nibble;

   // s_prev held the same vector for the whole stable run, so it is what gets captured.
   seg7_to_hex u_dec (
      .seg     (s_prev[6:0]),
      .invalid (cap_invalid),
      .nibble  (cap_nibble)
   );

   always_comb begin
      kind = AN_MULTI;
      idx  = 2'd0;
      case (~s_prev[10:7])
         4'b0000: kind = AN_BLANK;
         4'b0001: begin kind = AN_SINGLE; idx = 2'd0; end
         4'b0010: begin kind = AN_SINGLE; idx = 2'd1; end
         4'b0100: begin kind = AN_SINGLE; idx = 2'd2; end
         4'b1000: begin kind = AN_SINGLE; idx = 2'd3; end
         default: kind = AN_MULTI;
      endcase
   end

   assign capture    = (cnt == CNT_CAP) && !taken;
   assign cap_single = capture && (kind == AN_SINGLE);
   assign complete   = (seen == 4'b1111);
   // A capture in the expiry cycle (or a frame already full) takes priority over timeout.
   assign tout_fire  = (tcnt >= TOUT_HIT) && (seen != 4'b0000) && !complete && !cap_single;

   always_comb begin
      seen_n  = seen;
      bad_n   = bad;
      slots_n = slots;
      if (complete || tout_fire) begin
         seen_n = 4'b0000;
         bad_n  = 1'b0;
      end
      if (cap_single) begin
         slots_n[idx] = cap_invalid ? 4'h0 : cap_nibble;
         seen_n[idx]  = 1'b1;
         bad_n        = bad_n | cap_invalid;
      end
   end

   // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= '1;
         sync2      <= '1;
         s_prev     <= '1;
         cnt        <= '0;
         taken      <= 1'b0;
         seen       <= 4'b0000;
         bad        <= 1'b0;
         slots      <= '0;
         tcnt       <= '0;
         data       <= 16'h0000;
         data_valid <= 1'b0;
         frame_bad  <= 1'b0;
         seg_err    <= 1'b0;
         an_err     <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         sync1  <= {an, seg};
         sync2  <= sync1;
         s_prev <= sync2;

         if (sync2 != s_prev) begin
            cnt   <= '0;
            taken <= 1'b0;
         end else begin
            if (cnt != '1) cnt <= cnt + 1'b1;
            if (capture) taken <= 1'b1;
         end

         seen  <= seen_n;
         bad   <= bad_n;
         slots <= slots_n;

         if ((seen == 4'b0000) || (cap_single && !cap_invalid) || tout_fire)
            tcnt <= '0;
         else if (tcnt != '1)
            tcnt <= tcnt + 1'b1;

         data_valid <= complete;
         if (complete) begin
            data      <= slots;
            frame_bad <= bad;
         end
         seg_err <= cap_single && cap_invalid;
         an_err  <= capture && (kind == AN_MULTI);
         timeout <= tout_fire;
      end
   end

endmodule

// File: tb/tb_led_scan_capture.sv
// Directed bench for led_scan_capture: drives scan sequences on an/seg and checks the
// reconstructed words and error pulses against hand-computed values.
module tb_led_scan_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [15:0] data;
   logic        data_valid, frame_bad, seg_err, an_err, timeout;

   int compared   = 0;
   int mismatched = 0;

   int          dv_cnt = 0, se_cnt = 0, ae_cnt = 0, to_cnt = 0;
   logic [15:0] last_data = 16'h0;
   logic        last_bad = 1'b0;

   logic [6:0] pat [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   led_scan_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .an         (an),
      .seg        (seg),
      .data       (data),
      .data_valid (data_valid),
      .frame_bad  (frame_bad),
      .seg_err    (seg_err),
      .an_err     (an_err),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt    = dv_cnt + 1;
         last_data = data;
         last_bad  = frame_bad;
      end
      if (seg_err) se_cnt = se_cnt + 1;
      if (an_err)  ae_cnt = ae_cnt + 1;
      if (timeout) to_cnt = to_cnt + 1;
   end

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic show(input int k, input int d, input int n);
      logic [3:0] a;
      a = ~(4'b0001 << k);
      hold(a, pat[d], n);
   endtask

   task automatic blank(input int n);
      hold(4'b1111, 7'b1111111, n);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         an  = 4'($urandom);
         seg = 7'($urandom);
         @(negedge clk);
         compared++;
         if ({data, data_valid, frame_bad, seg_err, an_err, timeout} !== 21'h0) begin
            mismatched++;
            $display("FAIL reset_outputs cycle %0d: got data=%h dv=%b fb=%b se=%b ae=%b to=%b, need all 0",
                     i, data, data_valid, frame_bad, seg_err, an_err, timeout);
         end
      end
      an  = 4'b1111;
      seg = 7'b1111111;
      @(posedge clk);
      #1 reset = 1'b0;
      blank(8);
   endtask

   task automatic test_basic_frame;
      int dv0, se0;
      dv0 = dv_cnt; se0 = se_cnt;
      for (int k = 0; k < 4; k++) begin
         show(k, k + 1, 16);
         blank(2);
      end
      blank(6);
      compared++;
      if (dv_cnt - dv0 !== 1) begin
         mismatched++;
         $display("FAIL basic_dv_count: got %0d, need 1", dv_cnt - dv0);
      end
      compared++;
      if (last_data !== 16'h4321) begin
         mismatched++;
         $display("FAIL basic_data: got %h, need 4321", last_data);
      end
      compared++;
      if (last_bad !== 1'b0) begin
         mismatched++;
         $display("FAIL basic_frame_bad: got %b, need 0", last_bad);
      end
      compared++;
      if (se_cnt - se0 !== 0) begin
         mismatched++;
         $display("FAIL basic_seg_err: got %0d pulses, need 0", se_cnt - se0);
      end
   endtask

   task automatic test_glitch;
      int dv0;
      dv0 = dv_cnt;
      show(1, 6, 16);
      blank(2);
      show(0, 5, 16);
      show(1, 9, 2);
      show(0, 5, 16);
      blank(2);
      show(2, 7, 16);
      blank(2);
      show(3, 8, 16);
      blank(6);
      compared++;
      if (dv_cnt - dv0 !== 1) begin
         mismatched++;
         $display("FAIL glitch_dv_count: got %0d, need 1", dv_cnt - dv0);
      end
      compared++;
      if (last_data !== 16'h8765) begin
         mismatched++;
         $display("FAIL glitch_data: got %h, need 8765", last_data);
      end
      compared++;
      if (last_bad !== 1'b0) begin
         mismatched++;
         $display("FAIL glitch_frame_bad: got %b, need 0", last_bad);
      end
   endtask

   task automatic test_invalid_digit;
      int dv0, se0;
      dv0 = dv_cnt; se0 = se_cnt;
      show(0, 1, 16);
      blank(2);
      show(1, 2, 16);
      blank(2);
      hold(4'b1011, 7'b1111110, 16);
      blank(2);
      show(3, 4, 16);
      blank(6);
      compared++;
      if (se_cnt - se0 !== 1) begin
         mismatched++;
         $display("FAIL invalid_seg_err: got %0d pulses, need 1", se_cnt - se0);
      end
      compared++;
      if (dv_cnt - dv0 !== 1) begin
         mismatched++;
         $display("FAIL invalid_dv_count: got %0d, need 1", dv_cnt - dv0);
      end
      compared++;
      if (last_data !== 16'h4021) begin
         mismatched++;
         $display("FAIL invalid_data: got %h, need 4021", last_data);
      end
      compared++;
      if (last_bad !== 1'b1) begin
         mismatched++;
         $display("FAIL invalid_frame_bad: got %b, need 1", last_bad);
      end
   endtask

   task automatic test_multi_anode;
      int dv0, ae0, se0;
      dv0 = dv_cnt; ae0 = ae_cnt; se0 = se_cnt;
      show(0, 10, 16);
      blank(2);
      show(1, 11, 16);
      blank(2);
      hold(4'b1100, pat[8], 16);
      blank(2);
      show(2, 12, 16);
      blank(2);
      show(3, 13, 16);
      blank(6);
      compared++;
      if (ae_cnt - ae0 !== 1) begin
         mismatched++;
         $display("FAIL multi_an_err: got %0d pulses, need 1", ae_cnt - ae0);
      end
      compared++;
      if (dv_cnt - dv0 !== 1) begin
         mismatched++;
         $display("FAIL multi_dv_count: got %0d, need 1", dv_cnt - dv0);
      end
      compared++;
      if (last_data !== 16'hDCBA) begin
         mismatched++;
         $display("FAIL multi_data: got %h, need dcba", last_data);
      end
      compared++;
      if (se_cnt - se0 !== 0) begin
         mismatched++;
         $display("FAIL multi_seg_err: got %0d pulses, need 0", se_cnt - se0);
      end
   endtask

   task automatic test_timeout;
      int dv0, to0;
      dv0 = dv_cnt; to0 = to_cnt;
      show(0, 1, 16);
      blank(2);
      show(1, 2, 16);
      blank(100);
      compared++;
      if (to_cnt - to0 !== 1) begin
         mismatched++;
         $display("FAIL timeout_pulses: got %0d, need 1", to_cnt - to0);
      end
      compared++;
      if (dv_cnt - dv0 !== 0) begin
         mismatched++;
         $display("FAIL timeout_partial_dv: got %0d, need 0", dv_cnt - dv0);
      end
      show(3, 10, 16);
      blank(2);
      show(2, 11, 16);
      blank(2);
      show(1, 12, 16);
      blank(2);
      show(0, 13, 16);
      blank(6);
      compared++;
      if (dv_cnt - dv0 !== 1) begin
         mismatched++;
         $display("FAIL timeout_next_dv: got %0d, need 1", dv_cnt - dv0);
      end
      compared++;
      if (last_data !== 16'hABCD) begin
         mismatched++;
         $display("FAIL timeout_next_data: got %h, need abcd", last_data);
      end
      compared++;
      if (last_bad !== 1'b0) begin
         mismatched++;
         $display("FAIL timeout_next_frame_bad: got %b, need 0", last_bad);
      end
   endtask

   task automatic test_reset_mid_frame;
      int dv0;
      show(0, 1, 16);
      blank(2);
      show(1, 2, 16);
      blank(2);
      show(2, 3, 16);
      an    = 4'b1111;
      seg   = 7'b1111111;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      compared++;
      if (data !== 16'h0000) begin
         mismatched++;
         $display("FAIL midreset_data: got %h, need 0000", data);
      end
      dv0 = dv_cnt;
      blank(4);
      show(3, 4, 16);
      blank(10);
      compared++;
      if (dv_cnt - dv0 !== 0) begin
         mismatched++;
         $display("FAIL midreset_early_dv: got %0d, need 0", dv_cnt - dv0);
      end
      show(0, 5, 16);
      blank(2);
      show(1, 6, 16);
      blank(2);
      show(2, 7, 16);
      blank(6);
      compared++;
      if (dv_cnt - dv0 !== 1) begin
         mismatched++;
         $display("FAIL midreset_dv: got %0d, need 1", dv_cnt - dv0);
      end
      compared++;
      if (last_data !== 16'h4765) begin
         mismatched++;
         $display("FAIL midreset_data_frame: got %h, need 4765", last_data);
      end
   endtask

   initial begin
      an    = 4'b1111;
      seg   = 7'b1111111;
      reset = 1'b1;
      test_reset();
      test_basic_frame();
      test_glitch();
      test_invalid_digit();
      test_multi_anode();
      test_timeout();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
